// File: rtl/systolic_pkg.sv
// systolic_pkg: shared array constants and feeder FSM state encoding.
package systolic_pkg;
  localparam int LANES = 32;
  localparam int ELEM_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/systolic_skid_fifo.sv
// systolic_skid_fifo: 2-entry skid buffer with push/pop, occupancy count and head-of-queue output.
module systolic_skid_fifo #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign head = mem[rp];
endmodule

// File: rtl/systolic_buffer_feeder.sv
// systolic_buffer_feeder: walks the internal buffer read port through one tile and streams rows to the array.
// Optional SYSTOLIC_FEEDER_ZERO_PAD_EN: tail rows are generated as zeros instead of read from the buffer.
module systolic_buffer_feeder import systolic_pkg::*; #(
  parameter int DATAWIDTH  = 256,
  parameter int ROWS       = 512,
  parameter int DEPTH      = 543,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_rows,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATAWIDTH-1:0]  rd_data,
  output logic [DATAWIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  // DEPTH-ROWS is the skew tail length, so the last index is nr + (DEPTH-ROWS) - 1
  localparam logic [ADDR_WIDTH-1:0] TAIL = ADDR_WIDTH'(DEPTH - ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] MAXR = ADDR_WIDTH'(ROWS);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, last, nr_in, cnt_inc;
  logic [DATAWIDTH-1:0] din;
  logic [1:0] count;
  logic [2:0] occ;
  logic inflight, issue, pop, fin;
  assign nr_in = (num_rows == '0 || num_rows > MAXR) ? MAXR : num_rows;
  assign cnt_inc = cnt + 1'b1;
  assign out_valid = count != 2'd0;
  assign pop = out_valid & out_ready;
  // Occupancy the FIFO will have once the in-flight read lands and this cycle's pop leaves
  assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = state == RUN && occ < 3'd2;
  assign busy = state != IDLE;
  always_comb begin
    fin = state == DRAIN && !inflight && count == 2'd1 && pop;
    state_n = state == IDLE ? (start ? RUN : IDLE)
            : state == RUN  ? (issue && cnt == last ? DRAIN : RUN)
            : (fin ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
  logic [ADDR_WIDTH-1:0] nr;
  logic pad;
  assign din = pad ? '0 : rd_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      nr <= '0;
      pad <= 1'b0;
    end else begin
      pad <= issue && cnt >= nr;
      if (state == IDLE && start) nr <= nr_in;
    end
`else
  assign din = rd_data;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      last <= '0;
      rd_addr <= '0;
      inflight <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fin;
      inflight <= issue;
      if (state == IDLE && start) begin
        cnt <= '0;
        last <= nr_in + TAIL;
        rd_addr <= '0;
      end else if (issue && cnt != last) begin
        cnt <= cnt_inc;
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
        rd_addr <= cnt_inc < nr ? cnt_inc : rd_addr;
`else
        rd_addr <= cnt_inc;
`endif
      end
    end
  systolic_skid_fifo #(.W(DATAWIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .pop(pop),
    .din(din),
    .count(count),
    .head(out_data)
  );
endmodule

// File: tb/tb_systolic_buffer_feeder.sv
// tb_systolic_buffer_feeder: directed checks of the feeder against a registered-read buffer model.
module tb_systolic_buffer_feeder;
  logic clk = 1'b0;
  logic rst, start, out_ready, out_valid, busy, done;
  logic [9:0] num_rows, rd_addr;
  logic [255:0] rd_data, out_data;
  logic [255:0] bmem [543];
  int n_cmp = 0, n_err = 0, n_done = 0;
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= bmem[rd_addr];
  always @(posedge clk) if (done) n_done++;
  systolic_buffer_feeder dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_rows(num_rows),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );
  function automatic logic [255:0] row(input int j, input int nr);
    logic [7:0] b;
    b = j[7:0];
    return j < nr ? {32{b}} : '0;
  endfunction
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int nr);
    for (int i = 0; i < 543; i++)
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
      bmem[i] = i < nr ? row(i, nr) : {256{1'b1}};
`else
      bmem[i] = row(i, nr);
`endif
  endtask
  task automatic run_tile(input int nreq, input bit rnd, input int pulse_at);
    int nr, expn, beats, cyc, last_hs;
    bit seen, stall;
    logic [255:0] held;
    nr = (nreq == 0 || nreq > 512) ? 512 : nreq;
    expn = nr + 31;
    load(nr);
    start = 1'b1;
    num_rows = 10'(nreq);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_k1", busy, 1);
    chk("addr_k1", rd_addr, 0);
    beats = 0; seen = 0; stall = 0; last_hs = 0; cyc = 1; held = '0;
    while (!seen && cyc < 4000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = cyc == pulse_at;
      if (start) num_rows = 10'd5;
      @(negedge clk);
      if (stall) chk("stall_hold", out_data, held);
      if (out_valid && beats == 0 && !rnd) chk("first_cyc", cyc, 3);
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
      chk("addr_max", int'(rd_addr) <= nr - 1, 1);
`endif
      if (done) begin
        seen = 1;
        chk("done_cyc", cyc, last_hs + 1);
        chk("busy_done", busy, 0);
      end else begin
        stall = out_valid && !out_ready;
        held = out_data;
        if (out_valid && out_ready) begin
          chk("beat", out_data, row(beats, nr));
          beats++;
          last_hs = cyc;
        end
        @(posedge clk);
        #1 cyc++;
      end
    end
    start = 1'b0;
    chk("timeout", seen, 1);
    chk("beats", beats, expn);
    if (!rnd) chk("done_abs", cyc, expn + 3);
  endtask
  initial begin
    int d0, i;
    rst = 1'b1; start = 1'b0; num_rows = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_tile(512, 0, 0);
    @(posedge clk);
    #1;
    run_tile(512, 1, 0);
    @(posedge clk);
    #1;
    run_tile(0, 0, 0);
    @(posedge clk);
    #1;
    run_tile(600, 0, 0);
    @(posedge clk);
    #1;
    d0 = n_done;
    run_tile(1, 0, 10);
    run_tile(7, 0, 0);
    @(posedge clk);
    #1;
    chk("two_done", n_done - d0, 2);
    load(512);
    out_ready = 1'b1;
    start = 1'b1;
    num_rows = 10'd0;
    @(posedge clk);
    #1 start = 1'b0;
    i = 0;
    while (rd_addr != 10'd100 && i < 200) begin
      @(posedge clk);
      #1 i++;
    end
    chk("reach100", rd_addr, 100);
    rst = 1'b1;
    #2;
    chk("mid_valid", out_valid, 0);
    chk("mid_addr", rd_addr, 0);
    chk("mid_busy", busy, 0);
    chk("mid_data", out_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_tile(40, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
